// File: rtl/axi4_rd_arbiter_pkg.sv
// Shared definitions for the two-requester AXI4 read arbiter:
// FSM encodings and fixed AR-channel attribute values.
package axi4_rd_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_ADDR = 3'b010,
        S_DATA = 3'b100
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic       AXI_LOCK_NORMAL = 1'b0;
    localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
    localparam logic [2:0] AXI_PROT_NONE   = 3'b000;
    localparam logic [3:0] AXI_QOS_NONE    = 4'b0000;
    localparam logic [3:0] AXI_REGION_NONE = 4'b0000;

endpackage

// File: rtl/axi4_rd_arbiter_rr.sv
// Combinational 2-way round-robin pick: a lone request wins,
// a tie goes to the requester that was not granted last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// Shares one AXI4 read channel between two requesters, one burst
// at a time, round-robin at burst granularity.
module axi4_rd_arbiter
    import axi4_rd_arbiter_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic [AXI_ID_WIDTH-1:0]   s0_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic [7:0]                s0_axi_arlen,
    input  logic [2:0]                s0_axi_arsize,
    input  logic [1:0]                s0_axi_arburst,
    input  logic                      s0_axi_arvalid,
    output logic                      s0_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]   s0_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] s0_axi_rdata,
    output logic [1:0]                s0_axi_rresp,
    output logic                      s0_axi_rlast,
    output logic                      s0_axi_rvalid,
    input  logic                      s0_axi_rready,

    input  logic [AXI_ID_WIDTH-1:0]   s1_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic [7:0]                s1_axi_arlen,
    input  logic [2:0]                s1_axi_arsize,
    input  logic [1:0]                s1_axi_arburst,
    input  logic                      s1_axi_arvalid,
    output logic                      s1_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]   s1_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] s1_axi_rdata,
    output logic [1:0]                s1_axi_rresp,
    output logic                      s1_axi_rlast,
    output logic                      s1_axi_rvalid,
    input  logic                      s1_axi_rready,

    output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic [3:0]                m_axi_arregion,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,

    output logic                      busy,
    output logic [1:0]                grant
);

    state_t     state;
    state_t     state_next;
    logic [1:0] req;
    logic [1:0] pick;
    logic [1:0] grant_q;
    logic       last_grant;
    logic       owner_rready;
    logic       r_done;
    logic       take;

    assign req = {s1_axi_arvalid, s0_axi_arvalid};

    rr_arbiter2 u_rr (
        .req        (req),
        .last_grant (last_grant),
        .grant      (pick)
    );

    assign owner_rready = (grant_q[0] & s0_axi_rready)
                        | (grant_q[1] & s1_axi_rready);
    assign r_done = (state == S_DATA) & m_axi_rvalid
                  & owner_rready & m_axi_rlast;
    assign take = (state == S_IDLE) & (|pick);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // arready is masked during reset so no request is acked and then dropped
    always_comb begin
        state_next     = state;
        s0_axi_arready = 1'b0;
        s1_axi_arready = 1'b0;
        s0_axi_rvalid  = 1'b0;
        s1_axi_rvalid  = 1'b0;
        m_axi_rready   = 1'b0;
        unique case (state)
            S_IDLE: begin
                s0_axi_arready = pick[0] & ~reset;
                s1_axi_arready = pick[1] & ~reset;
                if (|pick) state_next = S_ADDR;
            end
            S_ADDR: begin
                if (m_axi_arready) state_next = S_DATA;
            end
            S_DATA: begin
                m_axi_rready  = owner_rready;
                s0_axi_rvalid = m_axi_rvalid & grant_q[0];
                s1_axi_rvalid = m_axi_rvalid & grant_q[1];
                if (m_axi_rvalid && owner_rready && m_axi_rlast)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q       <= 2'b00;
            last_grant    <= 1'b1;
            m_axi_arid    <= '0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_arsize  <= '0;
            m_axi_arburst <= '0;
        end else if (take) begin
            grant_q       <= pick;
            last_grant    <= pick[1];
            m_axi_arid    <= pick[1] ? s1_axi_arid    : s0_axi_arid;
            m_axi_araddr  <= pick[1] ? s1_axi_araddr  : s0_axi_araddr;
            m_axi_arlen   <= pick[1] ? s1_axi_arlen   : s0_axi_arlen;
            m_axi_arsize  <= pick[1] ? s1_axi_arsize  : s0_axi_arsize;
            m_axi_arburst <= pick[1] ? s1_axi_arburst : s0_axi_arburst;
        end else if (r_done) begin
            grant_q <= 2'b00;
        end
    end

    assign m_axi_arvalid  = (state == S_ADDR);
    assign busy           = (state != S_IDLE);
    assign grant          = grant_q;

    assign m_axi_arlock   = AXI_LOCK_NORMAL;
    assign m_axi_arcache  = AXI_CACHE_NONE;
    assign m_axi_arprot   = AXI_PROT_NONE;
    assign m_axi_arqos    = AXI_QOS_NONE;
    assign m_axi_arregion = AXI_REGION_NONE;

    assign s0_axi_rid   = m_axi_rid;
    assign s0_axi_rdata = m_axi_rdata;
    assign s0_axi_rresp = m_axi_rresp;
    assign s0_axi_rlast = m_axi_rlast;
    assign s1_axi_rid   = m_axi_rid;
    assign s1_axi_rdata = m_axi_rdata;
    assign s1_axi_rresp = m_axi_rresp;
    assign s1_axi_rlast = m_axi_rlast;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed scoreboard bench for axi4_rd_arbiter: single burst,
// AR/R back-pressure, reset mid-burst and round-robin ties.
module tb_axi4_rd_arbiter;
    import axi4_rd_arbiter_pkg::*;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] s0_axi_arid, s1_axi_arid;
    logic [AW-1:0] s0_axi_araddr, s1_axi_araddr;
    logic [7:0]    s0_axi_arlen, s1_axi_arlen;
    logic [2:0]    s0_axi_arsize, s1_axi_arsize;
    logic [1:0]    s0_axi_arburst, s1_axi_arburst;
    logic          s0_axi_arvalid, s1_axi_arvalid;
    logic          s0_axi_arready, s1_axi_arready;
    logic [IW-1:0] s0_axi_rid, s1_axi_rid;
    logic [DW-1:0] s0_axi_rdata, s1_axi_rdata;
    logic [1:0]    s0_axi_rresp, s1_axi_rresp;
    logic          s0_axi_rlast, s1_axi_rlast;
    logic          s0_axi_rvalid, s1_axi_rvalid;
    logic          s0_axi_rready, s1_axi_rready;
    logic [IW-1:0] m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arlock;
    logic [3:0]    m_axi_arcache;
    logic [2:0]    m_axi_arprot;
    logic [3:0]    m_axi_arqos;
    logic [3:0]    m_axi_arregion;
    logic          m_axi_arvalid, m_axi_arready;
    logic [IW-1:0] m_axi_rid;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic          busy;
    logic [1:0]    grant;

    always #5 clk = ~clk;

    axi4_rd_arbiter #(
        .AXI_DATA_WIDTH (DW),
        .AXI_ADDR_WIDTH (AW),
        .AXI_ID_WIDTH   (IW)
    ) dut (
        .clk (clk), .reset (reset),
        .s0_axi_arid (s0_axi_arid), .s0_axi_araddr (s0_axi_araddr),
        .s0_axi_arlen (s0_axi_arlen), .s0_axi_arsize (s0_axi_arsize),
        .s0_axi_arburst (s0_axi_arburst), .s0_axi_arvalid (s0_axi_arvalid),
        .s0_axi_arready (s0_axi_arready), .s0_axi_rid (s0_axi_rid),
        .s0_axi_rdata (s0_axi_rdata), .s0_axi_rresp (s0_axi_rresp),
        .s0_axi_rlast (s0_axi_rlast), .s0_axi_rvalid (s0_axi_rvalid),
        .s0_axi_rready (s0_axi_rready),
        .s1_axi_arid (s1_axi_arid), .s1_axi_araddr (s1_axi_araddr),
        .s1_axi_arlen (s1_axi_arlen), .s1_axi_arsize (s1_axi_arsize),
        .s1_axi_arburst (s1_axi_arburst), .s1_axi_arvalid (s1_axi_arvalid),
        .s1_axi_arready (s1_axi_arready), .s1_axi_rid (s1_axi_rid),
        .s1_axi_rdata (s1_axi_rdata), .s1_axi_rresp (s1_axi_rresp),
        .s1_axi_rlast (s1_axi_rlast), .s1_axi_rvalid (s1_axi_rvalid),
        .s1_axi_rready (s1_axi_rready),
        .m_axi_arid (m_axi_arid), .m_axi_araddr (m_axi_araddr),
        .m_axi_arlen (m_axi_arlen), .m_axi_arsize (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst), .m_axi_arlock (m_axi_arlock),
        .m_axi_arcache (m_axi_arcache), .m_axi_arprot (m_axi_arprot),
        .m_axi_arqos (m_axi_arqos), .m_axi_arregion (m_axi_arregion),
        .m_axi_arvalid (m_axi_arvalid), .m_axi_arready (m_axi_arready),
        .m_axi_rid (m_axi_rid), .m_axi_rdata (m_axi_rdata),
        .m_axi_rresp (m_axi_rresp), .m_axi_rlast (m_axi_rlast),
        .m_axi_rvalid (m_axi_rvalid), .m_axi_rready (m_axi_rready),
        .busy (busy), .grant (grant)
    );

    typedef struct {
        int            owner;
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [7:0]    len;
    } ar_exp_t;

    ar_exp_t       ar_q[$];
    logic [DW-1:0] d_q[$];
    int            tests = 0;
    int            fails = 0;
    bit            one[2];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    function automatic ar_exp_t exp_of(input int n);
        ar_exp_t e;
        e.owner = n;
        e.addr  = (n == 0) ? 32'h1000 : 32'h2000;
        e.id    = (n == 0) ? 4'd3 : 4'd5;
        e.len   = (n == 0) ? s0_axi_arlen : s1_axi_arlen;
        return e;
    endfunction

    // Serve one burst as the interconnect: wait for AR, hold arready low
    // for 'hold' cycles, then return 'beats' R beats carrying 0,1,2,...
    task automatic serve(input int beats, input bit tog, input int hold,
                         input int abort_at);
        ar_exp_t       e;
        bit            ok;
        bit [1:0]      rel;
        logic [AW-1:0] a0;
        logic          rr;
        logic [DW-1:0] dexp;
        int            c_own, c_oth, i;
        ok = 0; rel = 0; c_own = 0; c_oth = 0; i = 0;
        #1;
        for (int n = 0; n < 40 && !ok; n++) begin
            if (s0_axi_arready && one[0]) rel[0] = 1'b1;
            if (s1_axi_arready && one[1]) rel[1] = 1'b1;
            cyc();
            if (rel[0]) begin s0_axi_arvalid = 1'b0; one[0] = 0; rel[0] = 0; end
            if (rel[1]) begin s1_axi_arvalid = 1'b0; one[1] = 0; rel[1] = 0; end
            #1;
            if (m_axi_arvalid) ok = 1;
        end
        check("ar_seen", ok, 1);
        if (!ok) return;
        tests++;
        assert (ar_q.size() > 0) else begin
            fails++;
            $error("FAIL ar_q_pop observed=empty expected=entry");
        end
        if (ar_q.size() == 0) return;
        e = ar_q.pop_front();
        check("araddr", m_axi_araddr, e.addr);
        check("arid", m_axi_arid, e.id);
        check("arlen", m_axi_arlen, e.len);
        check("arburst", m_axi_arburst, AXI_BURST_INCR);
        check("grant", grant, (e.owner == 0) ? 2'b01 : 2'b10);
        check("busy_addr", busy, 1);
        a0 = m_axi_araddr;
        for (int n = 0; n < hold; n++) begin
            cyc();
            check("hold_arvalid", m_axi_arvalid, 1);
            check("hold_araddr", m_axi_araddr, a0);
            check("hold_other_arready",
                  (e.owner == 0) ? s1_axi_arready : s0_axi_arready, 0);
        end
        m_axi_arready = 1'b1;
        cyc();
        m_axi_arready = 1'b0;
        #1;
        check("ar_dropped", m_axi_arvalid, 0);
        for (int k = 0; k < beats; k++) d_q.push_back(DW'(k));
        for (int n = 0; n < 400 && i < beats; n++) begin
            rr = tog ? n[0] : 1'b1;
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = DW'(i);
            m_axi_rlast  = (i == beats - 1);
            m_axi_rid    = e.id;
            m_axi_rresp  = 2'b00;
            if (e.owner == 0) s0_axi_rready = rr; else s1_axi_rready = rr;
            #1;
            check("rready_mirror", m_axi_rready, rr);
            check("no_ar_in_data", m_axi_arvalid, 0);
            if (e.owner == 0 ? (s1_axi_rvalid && s1_axi_rready)
                             : (s0_axi_rvalid && s0_axi_rready)) c_oth++;
            if (e.owner == 0 ? (s0_axi_rvalid && s0_axi_rready)
                             : (s1_axi_rvalid && s1_axi_rready)) begin
                c_own++;
                dexp = (d_q.size() > 0) ? d_q.pop_front() : '1;
                check("rdata", (e.owner == 0) ? s0_axi_rdata : s1_axi_rdata, dexp);
                check("rid", (e.owner == 0) ? s0_axi_rid : s1_axi_rid, e.id);
            end
            if (m_axi_rready) i++;
            cyc();
            if (abort_at >= 0 && i > abort_at) return;
        end
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        s0_axi_rready = 1'b1;
        s1_axi_rready = 1'b1;
        #1;
        check("beats_owner", c_own, beats);
        check("beats_other", c_oth, 0);
        check("busy_after_rlast", busy, 0);
        check("grant_idle", grant, 2'b00);
        check("d_q_drained", d_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        s0_axi_arid = 4'd3; s0_axi_araddr = 32'h1000; s0_axi_arlen = 8'd31;
        s0_axi_arsize = 3'd3; s0_axi_arburst = AXI_BURST_INCR;
        s1_axi_arid = 4'd5; s1_axi_araddr = 32'h2000; s1_axi_arlen = 8'd3;
        s1_axi_arsize = 3'd3; s1_axi_arburst = AXI_BURST_INCR;
        s0_axi_arvalid = 1'b1; s1_axi_arvalid = 1'b0;
        s0_axi_rready = 1'b1; s1_axi_rready = 1'b1;
        m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0;
        m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b1;
        one[0] = 0; one[1] = 0;
        repeat (3) cyc();
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_araddr", m_axi_araddr, 0);
        check("rst_rready", m_axi_rready, 0);
        check("rst_s0_arready", s0_axi_arready, 0);
        check("rst_s0_rvalid", s0_axi_rvalid, 0);
        check("rst_tieoffs", {m_axi_arlock, m_axi_arcache, m_axi_arprot,
                              m_axi_arqos, m_axi_arregion}, 0);
        s0_axi_arvalid = 1'b0;
        m_axi_rvalid   = 1'b0;
        reset          = 1'b0;
        cyc();

        // single requester, 32-beat burst
        s0_axi_arvalid = 1'b1; one[0] = 1;
        ar_q.push_back(exp_of(0));
        serve(32, 0, 0, -1);

        // simultaneous request after s0: s1 wins, s0 waits out AR stall
        s1_axi_arvalid = 1'b1; one[1] = 1;
        s0_axi_arvalid = 1'b1; one[0] = 1;
        ar_q.push_back(exp_of(1));
        ar_q.push_back(exp_of(0));
        serve(4, 0, 5, -1);
        serve(32, 1, 0, -1);

        // reset after beat 10 of an s0 burst
        s0_axi_arvalid = 1'b1; one[0] = 1;
        ar_q.push_back(exp_of(0));
        serve(32, 0, 0, 10);
        reset = 1'b1;
        cyc();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_araddr", m_axi_araddr, 0);
        check("mid_rst_rready", m_axi_rready, 0);
        check("mid_rst_rvalid", {s0_axi_rvalid, s1_axi_rvalid}, 0);
        reset = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        d_q.delete();
        ar_q.delete();

        // continuous tie: s0 first after reset, then strict alternation
        s0_axi_arlen = 8'd3;
        s0_axi_arvalid = 1'b1; s1_axi_arvalid = 1'b1;
        one[0] = 0; one[1] = 0;
        ar_q.push_back(exp_of(0));
        ar_q.push_back(exp_of(1));
        ar_q.push_back(exp_of(0));
        ar_q.push_back(exp_of(1));
        repeat (4) serve(4, 0, 0, -1);
        s0_axi_arvalid = 1'b0; s1_axi_arvalid = 1'b0;
        repeat (3) cyc();
        check("end_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
